// File: rtl/assoc_buffer_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ lookup/update requests onto one
// associative_buffer port and returns the buffer's pre-update data/hit flag.
module assoc_buffer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int KEY_SIZE  = 4,
  parameter int DATA_SIZE = 4
) (
  input  logic                          clk,
  input  logic                          async_nreset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [2*NUM_REQ-1:0]          req_op,
  input  logic [KEY_SIZE*NUM_REQ-1:0]   req_key,
  input  logic [DATA_SIZE*NUM_REQ-1:0]  req_data,
  input  logic                          pause,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_SIZE-1:0]          rsp_data,
  output logic                          rsp_hit,
  output logic                          busy,
  output logic                          buf_en,
  output logic [1:0]                    buf_ctrl,
  output logic [KEY_SIZE-1:0]           buf_key,
  output logic [DATA_SIZE-1:0]          buf_data_in,
  input  logic [DATA_SIZE-1:0]          buf_data_out,
  input  logic                          buf_valid
);

  localparam int          IW      = $clog2(NUM_REQ);
  localparam logic [1:0]  OP_NONE = 2'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e        state, state_nxt;
  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  logic [1:0]    op_q;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          start;

  // Index 'k' positions after 'base', wrapping at NUM_REQ (need not be a power of two).
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int c;
    c = int'(base) + k;
    if (c >= NUM_REQ) c = c - NUM_REQ;
    return IW'(c);
  endfunction

  // Search starts just after the last served requester, so it ends up lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req[rr_idx(last, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(last, k);
      end
    end
  end

  assign start = (state == IDLE) && !pause && win_found;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operation latch, response capture and round-robin pointer.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      last        <= IW'(NUM_REQ - 1);
      idx         <= '0;
      op_q        <= OP_NONE;
      buf_key     <= '0;
      buf_data_in <= '0;
      rsp_data    <= '0;
      rsp_hit     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (start) begin
        idx         <= win_idx;
        op_q        <= req_op[2*int'(win_idx) +: 2];
        buf_key     <= req_key[KEY_SIZE*int'(win_idx) +: KEY_SIZE];
        buf_data_in <= req_data[DATA_SIZE*int'(win_idx) +: DATA_SIZE];
      end
      if (state == ISSUE) begin
        rsp_data <= buf_data_out;
        rsp_hit  <= buf_valid;
      end
      if (state == RESP) last <= idx;
    end
  end

  // Strobes are decoded from state and latched index only; no req-to-gnt path.
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    buf_en    = 1'b0;
    buf_ctrl  = OP_NONE;
    busy      = (state != IDLE);
    case (state)
      ISSUE: begin
        gnt[idx] = 1'b1;
        buf_en   = 1'b1;
        buf_ctrl = op_q;
      end
      RESP:    rsp_valid[idx] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_assoc_buffer_arbiter.sv
// Scoreboard bench for assoc_buffer_arbiter with a small behavioural
// associative buffer attached to the buffer port.
module tb_assoc_buffer_arbiter;

  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, INCR = 2'd2, CLR = 2'd3;

  logic        clk;
  logic        async_nreset;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [15:0] req_key;
  logic [15:0] req_data;
  logic        pause;
  logic [3:0]  gnt, rsp_valid;
  logic [3:0]  rsp_data;
  logic        rsp_hit, busy, buf_en;
  logic [1:0]  buf_ctrl;
  logic [3:0]  buf_key, buf_data_in, buf_data_out;
  logic        buf_valid;

  assoc_buffer_arbiter #(.NUM_REQ(4), .KEY_SIZE(4), .DATA_SIZE(4)) dut (
    .clk(clk), .async_nreset(async_nreset), .req(req), .req_op(req_op),
    .req_key(req_key), .req_data(req_data), .pause(pause), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .busy(busy),
    .buf_en(buf_en), .buf_ctrl(buf_ctrl), .buf_key(buf_key),
    .buf_data_in(buf_data_in), .buf_data_out(buf_data_out), .buf_valid(buf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-entry behavioural buffer; entries survive arbiter reset.
  bit       mv [4];
  bit [3:0] mk [4];
  bit [3:0] md [4];

  function automatic int find_hit(input logic [3:0] k);
    for (int i = 0; i < 4; i++) if (mv[i] && mk[i] == k) return i;
    return -1;
  endfunction

  function automatic int find_free();
    for (int i = 0; i < 4; i++) if (!mv[i]) return i;
    return -1;
  endfunction

  always_comb begin
    buf_valid    = 1'b0;
    buf_data_out = '0;
    for (int i = 0; i < 4; i++)
      if (mv[i] && mk[i] == buf_key) begin
        buf_valid    = 1'b1;
        buf_data_out = md[i];
      end
  end

  always @(posedge clk) begin
    if (buf_en) begin
      case (buf_ctrl)
        LOAD: if (find_hit(buf_key) >= 0) md[find_hit(buf_key)] <= buf_data_in;
              else if (find_free() >= 0) begin
                mv[find_free()] <= 1'b1;
                mk[find_free()] <= buf_key;
                md[find_free()] <= buf_data_in;
              end
        INCR: if (find_hit(buf_key) >= 0) md[find_hit(buf_key)] <= md[find_hit(buf_key)] + 4'd1;
        CLR:  if (find_hit(buf_key) >= 0) mv[find_hit(buf_key)] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Scoreboard
  typedef struct {int idx; logic [3:0] data; logic hit;} rsp_t;
  int   exp_gnt_q[$];
  rsp_t exp_rsp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic expect_op(input int i, input logic [3:0] d, input logic h);
    rsp_t r;
    r.idx = i; r.data = d; r.hit = h;
    exp_gnt_q.push_back(i);
    exp_rsp_q.push_back(r);
  endtask

  logic [3:0] prev_gnt;

  always @(negedge clk) begin
    if (!async_nreset) prev_gnt <= '0;
    else begin
      prev_gnt <= gnt;
      if (gnt != 0) begin
        if (exp_gnt_q.size() == 0) check("unexpected gnt", 32'(gnt), 0);
        else check("gnt order", 32'(gnt), 32'(1) << exp_gnt_q.pop_front());
      end
      if (rsp_valid != 0) begin
        check("rsp follows gnt", 32'(rsp_valid), 32'(prev_gnt));
        if (exp_rsp_q.size() == 0) check("unexpected rsp_valid", 32'(rsp_valid), 0);
        else begin
          check("rsp_valid idx", 32'(rsp_valid), 32'(1) << exp_rsp_q[0].idx);
          check("rsp_data", 32'(rsp_data), 32'(exp_rsp_q[0].data));
          check("rsp_hit", 32'(rsp_hit), 32'(exp_rsp_q[0].hit));
          exp_rsp_q.delete(0);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [1:0] op, input logic [3:0] key, input logic [3:0] data);
    req_op[2*i +: 2]   = op;
    req_key[4*i +: 4]  = key;
    req_data[4*i +: 4] = data;
    req[i]             = 1'b1;
  endtask

  // Drop each req once granted; return when all requests and the FSM are done.
  task automatic run(input int budget);
    int n = 0;
    while ((req != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
      req = req & ~gnt;
    end
    check("drain within budget", 32'(n < budget), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"}, 32'(gnt), 0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, " rsp_data"}, 32'(rsp_data), 0);
    check({tag, " rsp_hit"}, 32'(rsp_hit), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " buf_en"}, 32'(buf_en), 0);
    check({tag, " buf_ctrl"}, 32'(buf_ctrl), 0);
    check({tag, " buf_key"}, 32'(buf_key), 0);
    check({tag, " buf_data_in"}, 32'(buf_data_in), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ng;
    int gcyc [5];
    req = '0; req_op = '0; req_key = '0; req_data = '0; pause = 1'b0;
    async_nreset = 1'b1;
    #1 async_nreset = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) async_nreset = 1'b1;
    @(posedge clk); #1;

    // Single request to an empty buffer
    expect_op(2, 4'd0, 1'b0);
    issue(2, LOAD, 4'd5, 4'd9);
    @(posedge clk); #1;
    check("single gnt latency", 32'(gnt), 32'h4);
    req[2] = 1'b0;
    run(10);
    check("buffer key5 present", 32'(find_hit(4'd5) >= 0), 1);
    check("buffer key5 data", 32'(md[find_hit(4'd5)]), 9);

    // Hit response
    expect_op(0, 4'd9, 1'b1);
    issue(0, NONE, 4'd5, 4'd0);
    run(10);

    // Rotation: grant to 2, then 0 and 3 together -> 3 first
    expect_op(2, 4'd9, 1'b1);
    issue(2, INCR, 4'd5, 4'd0);
    run(10);
    expect_op(3, 4'd0, 1'b0);
    expect_op(0, 4'd10, 1'b1);
    issue(0, NONE, 4'd5, 4'd0);
    issue(3, LOAD, 4'd7, 4'd3);
    run(20);

    // Pause raised in the ISSUE cycle of requester 1 with requester 0 pending
    expect_op(1, 4'd10, 1'b1);
    expect_op(0, 4'd3, 1'b1);
    issue(1, NONE, 4'd5, 4'd0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!gnt[1] && n < 10);
    check("pause-case gnt 1 seen", 32'(gnt), 32'h2);
    pause = 1'b1;
    req[1] = 1'b0;
    issue(0, NONE, 4'd7, 4'd0);
    ng = 0;
    repeat (6) begin @(posedge clk); #1; if (gnt != 0) ng++; end
    check("no gnt while paused", 32'(ng), 0);
    check("idle while paused", 32'(busy), 0);
    pause = 1'b0;
    @(posedge clk); #1;
    check("gnt one cycle after unpause", 32'(gnt), 32'h1);
    req[0] = 1'b0;
    run(10);

    // Reset during ISSUE
    issue(2, LOAD, 4'd9, 4'd4);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!gnt[2] && n < 10);
    check("reset-case gnt 2 seen", 32'(gnt), 32'h4);
    async_nreset = 1'b0;
    req = '0;
    #1 check_all_zero("mid-op reset");
    @(negedge clk) async_nreset = 1'b1;
    expect_op(0, 4'd10, 1'b1);
    expect_op(1, 4'd3, 1'b1);
    issue(0, NONE, 4'd5, 4'd0);
    issue(1, NONE, 4'd7, 4'd0);
    run(20);

    // Fairness: all four held high from reset
    async_nreset = 1'b0;
    issue(0, NONE, 4'd5, 4'd0);
    issue(1, NONE, 4'd7, 4'd0);
    issue(2, NONE, 4'd1, 4'd0);
    issue(3, NONE, 4'd5, 4'd0);
    expect_op(0, 4'd10, 1'b1);
    expect_op(1, 4'd3, 1'b1);
    expect_op(2, 4'd0, 1'b0);
    expect_op(3, 4'd10, 1'b1);
    expect_op(0, 4'd10, 1'b1);
    @(negedge clk) async_nreset = 1'b1;
    n = 0; ng = 0;
    while (ng < 5 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (gnt != 0) begin
        gcyc[ng] = n;
        ng++;
        if (ng == 5) req = '0;
      end
    end
    check("fairness five grants", 32'(ng), 5);
    check("fairness first gnt latency", 32'(gcyc[0]), 1);
    for (int k = 0; k < 4; k++)
      check("fairness gnt spacing", 32'(gcyc[k+1] - gcyc[k]), 3);
    run(10);

    repeat (3) @(posedge clk);
    check("gnt queue drained", 32'(exp_gnt_q.size()), 0);
    check("rsp queue drained", 32'(exp_rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/assoc_buffer_arbiter.md
# assoc_buffer_arbiter

Round-robin controller that shares one `associative_buffer` instance between `NUM_REQ` requesters. Each requester posts a lookup/update operation (key, data, op) with a req/gnt handshake; the arbiter serialises operations onto the buffer's single key/data/ctrl port. It captures the buffer's pre-update `data_out`/`valid` and returns them to the granted requester as a one-cycle response. It sits between the user-side logic (switch/button decoders, test sequencers) and the buffer datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `KEY_SIZE`, 4: key width, matches buffer
- `DATA_SIZE`, 4: data width, matches buffer
- `clk`  in  1  clock, all state on rising edge
- `async_nreset`  in  1  reset, asynchronous, active-low
- `req`  in  NUM_REQ  per-requester request level
- `req_op`  in  2*NUM_REQ  flattened op per requester, bits [2i+1:2i]; 0 NONE, 1 LOAD, 2 INCR, 3 CLR
- `req_key`  in  KEY_SIZE*NUM_REQ  flattened keys
- `req_data`  in  DATA_SIZE*NUM_REQ  flattened write data
- `pause`  in  1  when 1, no new grant is issued
- `gnt`  out  NUM_REQ  one-hot grant pulse
- `rsp_valid`  out  NUM_REQ  one-hot response pulse
- `rsp_data`  out  DATA_SIZE  buffer data before the update
- `rsp_hit`  out  1  key was present before the update
- `busy`  out  1  state != IDLE
- `buf_en`  out  1  strobe; buffer acts only when 1
- `buf_ctrl`  out  2  op to buffer
- `buf_key`  out  KEY_SIZE  key to buffer
- `buf_data_in`  out  DATA_SIZE  data to buffer
- `buf_data_out`  in  DATA_SIZE  combinational buffer read data
- `buf_valid`  in  1  combinational buffer hit flag

## Operation
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if `pause`=0 and `req`!=0, select the winner, latch its op/key/data and index, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): `buf_en`=1 and `buf_ctrl`/`buf_key`/`buf_data_in` driven from the latched values. `gnt[idx]`=1. At the closing edge, `buf_data_out`→`rsp_data` and `buf_valid`→`rsp_hit` are captured. Go to RESP.
  - RESP (1 cycle): `rsp_valid[idx]`=1. Update `last` = idx. Go to IDLE.
- Round-robin selection: search indices `last+1`, `last+2`, … modulo NUM_REQ; the first asserted `req` wins. `last` resets to NUM_REQ-1, so requester 0 has first priority.
- In IDLE and RESP: `buf_en`=0, `buf_ctrl`=NONE (0), and `buf_key`/`buf_data_in` hold their latched values (0 after reset).
- Requester rule: hold `req`/op/key/data stable until `gnt`, and drop `req` in the cycle after `gnt` unless another operation is wanted. A `req` still high in IDLE after RESP is re-arbitrated normally; it receives no priority over the others.
- Inputs of non-granted requesters are ignored. A `req` dropped before selection is never granted.
- `pause` is sampled only in IDLE. An operation already in ISSUE/RESP always completes.
- `rsp_data`/`rsp_hit` hold their value until the next capture.
- Buffer full with miss: the buffer does not insert. The arbiter reports `rsp_hit`=0 and takes no other action.

## Timing
- Reset (async assert, sync deassert assumed at top level) forces:
  - state IDLE, `last`=NUM_REQ-1
  - `gnt`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_hit`=0, `busy`=0
  - `buf_en`=0, `buf_ctrl`=0, `buf_key`=0, `buf_data_in`=0
- Outputs are registered or decoded from state only. There is no combinational path from `req` to `gnt`.
- Latency: `req` seen in IDLE at edge E. `gnt` is high in cycle E+1, `rsp_valid` is high in cycle E+2, and the next grant is possible at E+4 (ISSUE of the next op). Throughput is one operation per 3 cycles under continuous load.
- Reset mid-ISSUE: the buffer write may or may not occur, depending on the edge. No `rsp_valid` is produced. After reset, arbitration restarts with requester 0 priority.
- Simultaneous `pause` rise and `req` in IDLE: no grant.

## Test plan
- Single request: requester 2 asserts `req`, op LOAD, key 5, data 9, on an empty buffer. Required: `gnt`=0100 one cycle later; buffer entry key 5 = 9; `rsp_valid`=0100 next cycle with `rsp_hit`=0.
- Hit response: after the previous case, requester 0 issues op NONE, key 5. Required: `rsp_hit`=1 and `rsp_data`=9.
- Fairness: all four `req` held high continuously from reset. Required: grant order 0,1,2,3,0; `gnt` pulses spaced exactly 3 cycles apart.
- Rotation: after grant to 2, only requesters 0 and 3 request. Required: 3 is granted before 0.
- Pause: `pause`=1 raised in the ISSUE cycle of a grant to requester 1, with `req` 0 pending. Required: requester 1's RESP completes, no further `gnt` appears while paused, and requester 0 is granted 1 cycle after `pause` falls.
- Reset mid-op: `async_nreset` pulsed low during ISSUE. Required: all outputs read 0 immediately, with no `rsp_valid`; the next grant goes to the lowest-index requester.
